// File: rtl/ysyx_25030093_inst_queue.sv
// Instruction queue between IFU and IDU.
// Buffers {pc, inst} pairs from the fetch handshake and replays them in order to decode.
// Ports:
//   clk, rst          clock; asynchronous active-low reset
//   in_valid/in_ready IFU handshake; in_ready depends only on queue state
//   in_pc, in_inst    fetched pair
//   out_valid/ready   IDU handshake; out_* read registered head entry
//   out_pc, out_inst  head entry
//   out_misalign      head entry pc[1:0] != 0
//   flush             drop every entry (highest priority)
//   count             number of valid entries, 0..DEPTH
module ysyx_25030093_inst_queue #(
    parameter int unsigned DEPTH  = 2,
    parameter int unsigned ADDR_W = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [31:0]       in_pc,
    input  logic [31:0]       in_inst,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [31:0]       out_pc,
    output logic [31:0]       out_inst,
    output logic              out_misalign,
    input  logic              flush,
    output logic [ADDR_W:0]   count
);

    localparam logic [ADDR_W:0] PtrOne = (ADDR_W + 1)'(1);

    // Entry layout: {misalign, pc, inst}
    logic [64:0]     mem_q [DEPTH];
    logic [ADDR_W:0] rd_ptr_q, rd_ptr_d;
    logic [ADDR_W:0] wr_ptr_q, wr_ptr_d;
    logic            empty, full, push, pop;
    logic [64:0]     head;

    // Pointers carry an extra wrap bit to tell full from empty.
    assign empty = (rd_ptr_q == wr_ptr_q);
    assign full  = (rd_ptr_q[ADDR_W-1:0] == wr_ptr_q[ADDR_W-1:0]) &&
                   (rd_ptr_q[ADDR_W] != wr_ptr_q[ADDR_W]);

    assign in_ready  = !full;
    assign out_valid = !empty;
    assign push      = in_valid && in_ready && !flush;
    assign pop       = out_valid && out_ready && !flush;
    assign count     = wr_ptr_q - rd_ptr_q;

    assign head         = mem_q[rd_ptr_q[ADDR_W-1:0]];
    assign out_misalign = head[64];
    assign out_pc       = head[63:32];
    assign out_inst     = head[31:0];

    always_comb begin
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        if (flush) begin
            rd_ptr_d = '0;
            wr_ptr_d = '0;
        end else begin
            if (push) wr_ptr_d = wr_ptr_q + PtrOne;
            if (pop)  rd_ptr_d = rd_ptr_q + PtrOne;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
        end else begin
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
        end
    end

    // Storage is not reset; out_* are only meaningful while out_valid.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q[ADDR_W-1:0]] <= {(in_pc[1:0] != 2'b00), in_pc, in_inst};
        end
    end

endmodule
